sr_serial_driver: RTL
=====================

# sr_serial_driver

Parallel-to-serial driver that feeds the N-bit serial shift/latch stage of the Kanalog buffer. It accepts one N-bit word over a valid/ready handshake and produces the single-cycle `sclk` shift strobes and the `ser_in` bit stream, LSB first, at a programmable bit rate. It then issues one `rclk` strobe that transfers the shifted word to the latch's parallel outputs. It shares the latch's clock and `clr`, and its strobe outputs connect directly to the latch's strobe inputs.

## Interface
- `N`, default 8: word width; must equal the downstream latch width.
- `DIV_W`, default 8: width of the bit-period divider input.

Ports:
- `clk`  in  1: system clock; all logic on the rising edge.
- `clr`  in  1: synchronous, active-high reset. Also drives the downstream latch's `clr`.
- `div`  in  DIV_W: bit period minus one, in `clk` cycles. Sampled only at word acceptance.
- `in_data`  in  N: word to send.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: the driver can accept a word this cycle.
- `ser_in`  out  1: serial data to the latch.
- `sclk`  out  1: single-cycle shift strobe.
- `rclk`  out  1: single-cycle transfer strobe.
- `busy`  out  1: a word is in progress.

## Operation
- States: IDLE, SHIFT, LATCH.
- IDLE:
  - `in_ready` = 1 exactly when the state is IDLE and `clr` is low.
  - Acceptance happens on the edge where `in_valid & in_ready`.
  - At acceptance the driver captures `in_data` into the shift word and `div` into the period register `P`, sets bit index 0, and moves to SHIFT.
- SHIFT:
  - Bit k (k = 0..N-1) is `in_data[k]`; LSB is sent first, so after N shifts the latch holds the word in its original bit order.
  - Each bit lasts P+1 cycles. `ser_in` holds the bit for the whole period.
  - `sclk` = 1 only in the last cycle of each bit period.
  - After the strobe for bit N-1, the state moves to LATCH.
- LATCH:
  - Lasts P+1 cycles with `ser_in` = 0 and `sclk` = 0.
  - `rclk` = 1 in the last cycle only, then the state returns to IDLE.
- `sclk` and `rclk` are never high in the same cycle.
- `busy` = 1 in SHIFT and LATCH.
- `in_valid` outside IDLE is ignored; the upstream holds its data until `in_ready`.
- Changes on `div` or `in_data` after acceptance have no effect on the word in progress.

## Timing
- All outputs are registered except `in_ready`, which decodes state and `clr`.
- Reset values (on any edge with `clr` = 1): state IDLE; `ser_in`, `sclk`, `rclk`, `busy` = 0; shift word and `P` = 0. `in_ready` is 0 while `clr` is high and 1 in the first cycle after it falls.
- Numbering: the acceptance edge ends cycle 0. Bit k occupies cycles k(P+1)+1 .. (k+1)(P+1). `sclk` is high in cycle (k+1)(P+1).
- `rclk` is high in cycle (N+1)(P+1). The latch's parallel output updates on the edge that ends that cycle.
- `in_ready` returns to 1 in cycle (N+1)(P+1)+1. The minimum word-to-word interval is therefore (N+1)(P+1)+1 cycles.
- With `div` = 0, `sclk` is high in cycles 1..N and `rclk` in cycle N+1.
- `clr` mid-word: the next cycle is IDLE with all outputs 0 and no `rclk`. The latch is cleared by the same `clr`, so no partial word ever appears.
- Bit counter wraps at N-1, with no off-by-one at N = 1.
- Period counter counts down from P; the strobe fires when it reads 0. It reloads at every bit and phase boundary.
- The counter needs DIV_W bits and the bit index needs $clog2(N) bits, minimum 1.

## Structure
- A shared package `sr_pkg` holds the state enum (IDLE, SHIFT, LATCH) and the default `N` and `DIV_W` constants, so the driver and latch benches agree on widths.
- One natural sub-module, `sr_bit_timer`:
  - Inputs: load value P, `load`, `run`.
  - Output: `tick` in the last cycle of each period.
- The FSM, shift word, and bit index stay in `sr_serial_driver`.

## Test plan
- `N` = 8, `div` = 0, accept 0xA5:
  - `ser_in` over cycles 1..8 = 1,0,1,0,0,1,0,1.
  - `sclk` high in cycles 1..8; `rclk` in cycle 9.
  - Downstream latch `par_out` = 0xA5 from cycle 10; `in_ready` = 1 in cycle 10.
- `div` = 2, accept 0x3C:
  - Each bit held 3 cycles; `sclk` in cycles 3,6,…,24; `rclk` in cycle 27.
  - `busy` high in cycles 1..27; latch reads 0x3C.
- Back-to-back: `in_valid` held high with 0x01 then 0xFE.
  - The second word is accepted in cycle 10 (`div` = 0).
  - Latch shows 0x01, then 0xFE from cycle 20.
- Word in flight:
  - `in_valid` with 0xFF pulsed during SHIFT is not accepted.
  - Changing `div` mid-word does not alter the period of the current word.
- `clr` high in cycle 5 of a `div` = 0 word:
  - From cycle 6, all outputs are 0 and latch `par_out` = 0.
  - No `rclk` occurs; `in_ready` = 1 in the first cycle after `clr` falls.
- `N` = 1, `div` = 0, accept 1: `ser_in` = 1 and `sclk` in cycle 1; `rclk` in cycle 2; latch = 1.

Source files
------------

// File: rtl/sr_pkg.sv
// Shared types and default widths for the serial driver and its downstream latch.
package sr_pkg;

   localparam int SR_N_DEFAULT     = 8;
   localparam int SR_DIV_W_DEFAULT = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_LATCH = 2'd2
   } sr_state_e;

endpackage

// File: rtl/sr_bit_timer.sv
// Down-counting period timer: ticks in the last cycle of every (load_val+1)-cycle period.
module sr_bit_timer #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [DIV_W-1:0] load_val,
   input  logic             load,
   input  logic             run,
   output logic             tick,
   output logic             tick_next
);

   localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

   logic [DIV_W-1:0] cnt_q;
   logic [DIV_W-1:0] cnt_d;

   // Reload on tick so each bit and the latch phase get a fresh period.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (run) begin
         cnt_d = (cnt_q == '0) ? load_val : (cnt_q - ONE);
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick      = run && (cnt_q == '0);
   // Lets the parent register its strobes one cycle ahead of the period end.
   assign tick_next = (cnt_d == '0);

endmodule

// File: rtl/sr_serial_driver.sv
// Parallel-to-serial driver: shifts one word LSB first with sclk strobes, then pulses rclk.
module sr_serial_driver
   import sr_pkg::*;
#(
   parameter int N     = SR_N_DEFAULT,
   parameter int DIV_W = SR_DIV_W_DEFAULT
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [DIV_W-1:0] div,
   input  logic [N-1:0]     in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             ser_in,
   output logic             sclk,
   output logic             rclk,
   output logic             busy
);

   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   sr_state_e        state_q, state_d;
   logic [N-1:0]     word_q, word_d;
   logic [DIV_W-1:0] p_q, p_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             ser_in_q, ser_in_d;
   logic             sclk_q, sclk_d;
   logic             rclk_q, rclk_d;
   logic             busy_q, busy_d;

   logic accept;
   logic tick;
   logic tick_next;

   assign in_ready = (state_q == ST_IDLE) && !clr;
   assign accept   = in_valid && in_ready;

   sr_bit_timer #(.DIV_W(DIV_W)) u_timer (
      .clk       (clk),
      .clr       (clr),
      .load_val  (accept ? div : p_q),
      .load      (accept),
      .run       (state_q != ST_IDLE),
      .tick      (tick),
      .tick_next (tick_next)
   );

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      p_d     = p_q;
      idx_d   = idx_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_SHIFT;
               word_d  = in_data;
               p_d     = div;
               idx_d   = '0;
            end
         end
         ST_SHIFT: begin
            if (tick) begin
               if (idx_q == LAST_IDX) begin
                  state_d = ST_LATCH;
               end else begin
                  idx_d  = idx_q + IDX_W'(1);
                  word_d = word_q >> 1;
               end
            end
         end
         ST_LATCH: begin
            if (tick) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Outputs are decoded from next state so they can be registered without a cycle of lag.
      ser_in_d = (state_d == ST_SHIFT) && word_d[0];
      sclk_d   = (state_d == ST_SHIFT) && tick_next;
      rclk_d   = (state_d == ST_LATCH) && tick_next;
      busy_d   = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q  <= ST_IDLE;
         word_q   <= '0;
         p_q      <= '0;
         idx_q    <= '0;
         ser_in_q <= 1'b0;
         sclk_q   <= 1'b0;
         rclk_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         word_q   <= word_d;
         p_q      <= p_d;
         idx_q    <= idx_d;
         ser_in_q <= ser_in_d;
         sclk_q   <= sclk_d;
         rclk_q   <= rclk_d;
         busy_q   <= busy_d;
      end
   end

   assign ser_in = ser_in_q;
   assign sclk   = sclk_q;
   assign rclk   = rclk_q;
   assign busy   = busy_q;

endmodule
